// File: rtl/draw_pkg.sv
// Shared constants for the board draw engine: command codes, colours, default geometry,
// FSM state type and the tile palette.
package draw_pkg;

    localparam logic [2:0] CMD_CLEAR  = 3'd0;
    localparam logic [2:0] CMD_GRID   = 3'd1;
    localparam logic [2:0] CMD_EZ     = 3'd2;
    localparam logic [2:0] CMD_NORMAL = 3'd3;
    localparam logic [2:0] CMD_HARD   = 3'd4;
    localparam logic [2:0] CMD_NUM    = 3'd5;

    localparam logic [2:0] BLACK  = 3'd0;
    localparam logic [2:0] GREEN  = 3'd2;
    localparam logic [2:0] RED    = 3'd4;
    localparam logic [2:0] YELLOW = 3'd6;
    localparam logic [2:0] WHITE  = 3'd7;

    localparam int unsigned SCR_W      = 160;
    localparam int unsigned SCR_H      = 120;
    localparam int unsigned DEF_X0     = 40;
    localparam int unsigned DEF_Y0     = 20;
    localparam int unsigned DEF_TILE   = 20;
    localparam int unsigned BANNER_H   = 8;
    localparam int unsigned BANNER_GAP = 4;
    localparam int unsigned NUM_TILES  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StFetch,
        StLatch,
        StDone
    } state_e;

    // Blank tiles are black; values 1..15 cycle through colours 1..7.
    function automatic logic [2:0] tile_colour(input logic [3:0] val);
        logic [3:0] m;
        m = val % 4'd7;
        if (val == 4'd0) return BLACK;
        return 3'(m + 4'd1);
    endfunction

endpackage

// File: rtl/board_draw_engine_if.sv
// Command, board-store and pixel-write signals of the board draw engine.
interface board_draw_engine_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic [3:0] tile_addr;
    logic [3:0] tile_val;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (
        output cmd_valid, cmd, tile_val,
        input  cmd_ready, busy, done, tile_addr, x, y, colour, plot
    );

    modport slave (
        input  cmd_valid, cmd, tile_val,
        output cmd_ready, busy, done, tile_addr, x, y, colour, plot
    );
endinterface

// File: rtl/rect_scanner.sv
// Rectangle raster walker: loaded with origin and size, steps x inner / y outer one pixel
// per enabled cycle and flags the end of each row and the final pixel.
module rect_scanner (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_x0,
    input  logic [6:0] i_y0,
    input  logic [7:0] i_w,
    input  logic [6:0] i_h,
    output logic [7:0] o_x,
    output logic [6:0] o_y,
    output logic       o_row_end,
    output logic       o_last
);

    logic [7:0] r_x;
    logic [7:0] r_x0;
    logic [7:0] r_xe;
    logic [6:0] r_y;
    logic [6:0] r_ye;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x  <= '0;
            r_x0 <= '0;
            r_xe <= '0;
            r_y  <= '0;
            r_ye <= '0;
        end else if (i_load) begin
            r_x  <= i_x0;
            r_x0 <= i_x0;
            r_xe <= i_x0 + i_w - 8'd1;
            r_y  <= i_y0;
            r_ye <= i_y0 + i_h - 7'd1;
        end else if (i_step && !o_last) begin
            if (o_row_end) begin
                r_x <= r_x0;
                r_y <= r_y + 7'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_row_end = (r_x == r_xe);
    assign o_last    = o_row_end && (r_y == r_ye);

endmodule

// File: rtl/board_draw_engine.sv
// Sliding-puzzle renderer: turns one drawing command into single-pixel writes.
// Optional macro BLANK_SKIP_EN skips painting of blank (value 0) tiles in NUM.
module board_draw_engine
    import draw_pkg::*;
#(
    parameter int unsigned X0   = DEF_X0,
    parameter int unsigned Y0   = DEF_Y0,
    parameter int unsigned TILE = DEF_TILE
) (
    input logic                clk,
    input logic                resetn,
    board_draw_engine_if.slave bus
);

    localparam logic [7:0] GridW    = 8'(4 * TILE + 1);
    localparam logic [6:0] GridH    = 7'(4 * TILE + 1);
    localparam logic [7:0] BannerW  = 8'(4 * TILE);
    localparam logic [6:0] BannerH  = 7'(BANNER_H);
    localparam logic [6:0] BannerY  = 7'(Y0 + 4 * TILE + BANNER_GAP);
    localparam logic [7:0] TileInW  = 8'(TILE - 1);
    localparam logic [6:0] TileInH  = 7'(TILE - 1);
    localparam logic [7:0] TileMax  = 8'(TILE - 1);
    localparam logic [3:0] LastTile = 4'(NUM_TILES - 1);

    state_e     r_state;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_plot;
    logic [2:0] r_cmd;
    logic [2:0] r_colour;
    logic [2:0] r_tile_col;
    logic [3:0] r_idx;
    logic [3:0] r_tile_addr;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [7:0] r_gx;
    logic [7:0] r_gy;

    logic       w_accept;
    logic       w_load;
    logic       w_step;
    logic       w_row_end;
    logic       w_last;
    logic       w_on_line;
    logic [2:0] w_sel;
    logic [2:0] w_colour;
    logic [7:0] w_ld_x;
    logic [7:0] w_ld_w;
    logic [6:0] w_ld_y;
    logic [6:0] w_ld_h;
    logic [7:0] w_tile_x;
    logic [6:0] w_tile_y;
    logic [7:0] w_sx;
    logic [6:0] w_sy;

    assign w_accept = (r_state == StIdle) && bus.cmd_valid && r_ready;
    assign w_load   = w_accept || (r_state == StFetch);
    assign w_step   = (r_state == StScan);
    assign w_sel    = (r_state == StIdle) ? bus.cmd : CMD_NUM;
    assign w_tile_x = 8'(X0 + 1 + TILE * r_idx[1:0]);
    assign w_tile_y = 7'(Y0 + 1 + TILE * r_idx[3:2]);

    always_comb begin
        w_ld_x = 8'(X0);
        w_ld_y = 7'(Y0);
        w_ld_w = GridW;
        w_ld_h = GridH;
        case (w_sel)
            CMD_CLEAR: begin
                w_ld_x = '0;
                w_ld_y = '0;
                w_ld_w = 8'(SCR_W);
                w_ld_h = 7'(SCR_H);
            end
            CMD_EZ, CMD_NORMAL, CMD_HARD: begin
                w_ld_y = BannerY;
                w_ld_w = BannerW;
                w_ld_h = BannerH;
            end
            CMD_NUM: begin
                w_ld_x = w_tile_x;
                w_ld_y = w_tile_y;
                w_ld_w = TileInW;
                w_ld_h = TileInH;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_cmd)
            CMD_GRID:   w_colour = WHITE;
            CMD_EZ:     w_colour = GREEN;
            CMD_NORMAL: w_colour = YELLOW;
            CMD_HARD:   w_colour = RED;
            CMD_NUM:    w_colour = r_tile_col;
            default:    w_colour = BLACK;
        endcase
    end

    rect_scanner u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_x0      (w_ld_x),
        .i_y0      (w_ld_y),
        .i_w       (w_ld_w),
        .i_h       (w_ld_h),
        .o_x       (w_sx),
        .o_y       (w_sy),
        .o_row_end (w_row_end),
        .o_last    (w_last)
    );

    // Grid-line mask: offsets modulo TILE tracked by wrapping counters in step with the scanner.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gx <= '0;
            r_gy <= '0;
        end else if (w_load) begin
            r_gx <= '0;
            r_gy <= '0;
        end else if (w_step) begin
            if (w_row_end) begin
                r_gx <= '0;
                r_gy <= (r_gy == TileMax) ? 8'd0 : r_gy + 8'd1;
            end else begin
                r_gx <= (r_gx == TileMax) ? 8'd0 : r_gx + 8'd1;
            end
        end
    end

    assign w_on_line = (r_gx == 8'd0) || (r_gy == 8'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_plot      <= 1'b0;
            r_cmd       <= '0;
            r_colour    <= '0;
            r_tile_col  <= '0;
            r_idx       <= '0;
            r_tile_addr <= '0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cmd       <= bus.cmd;
                        r_idx       <= '0;
                        r_tile_addr <= '0;
                        case (bus.cmd)
                            CMD_CLEAR, CMD_GRID, CMD_EZ, CMD_NORMAL, CMD_HARD: r_state <= StScan;
                            CMD_NUM: r_state <= StFetch;
                            default: r_state <= StDone;
                        endcase
                    end
                end
                StFetch: r_state <= StLatch;
                StLatch: begin
                    r_tile_col <= tile_colour(bus.tile_val);
                    r_state    <= StScan;
`ifdef BLANK_SKIP_EN
                    if (bus.tile_val == 4'd0) begin
                        if (r_idx == LastTile) begin
                            r_state <= StDone;
                        end else begin
                            r_idx       <= r_idx + 4'd1;
                            r_tile_addr <= r_idx + 4'd1;
                            r_state     <= StFetch;
                        end
                    end
`endif
                end
                StScan: begin
                    r_x      <= w_sx;
                    r_y      <= w_sy;
                    r_colour <= w_colour;
                    r_plot   <= (r_cmd != CMD_GRID) || w_on_line;
                    if (w_last) begin
                        if ((r_cmd == CMD_NUM) && (r_idx != LastTile)) begin
                            r_idx       <= r_idx + 4'd1;
                            r_tile_addr <= r_idx + 4'd1;
                            r_state     <= StFetch;
                        end else begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.plot      = r_plot;
    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.colour    = r_colour;
    assign bus.tile_addr = r_tile_addr;

endmodule

// File: tb/tb_board_draw_engine.sv
// Self-checking bench for board_draw_engine: captures every plotted pixel into an image and
// compares it, plus timing, against a frame-level model of each drawing command.
module tb_board_draw_engine;
    import draw_pkg::*;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int X0 = 40;
    localparam int Y0 = 20;
    localparam int T  = 20;
`ifdef BLANK_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    board_draw_engine_if bus ();

    board_draw_engine #(.X0(X0), .Y0(Y0), .TILE(T)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Board store with a synchronous read port.
    logic [3:0] board [16];
    always @(posedge clk) bus.tile_val <= board[bus.tile_addr];

    int n_checks = 0;
    int n_errors = 0;

    int img     [W][H];
    int exp_img [W][H];
    int exp_lat, exp_plots, exp_first_k;

    int res_lat, res_plots, res_first_k, res_fx, res_fy, res_lx, res_ly, res_bad;
    bit res_busy_ok, res_ready_after;
    bit res_abort_pre, res_abort_plot, res_abort_busy, res_abort_seen;

    task automatic clr_exp();
        for (int i = 0; i < W; i++) for (int j = 0; j < H; j++) exp_img[i][j] = -1;
    endtask

    function automatic int img_diffs();
        int n = 0;
        for (int i = 0; i < W; i++) for (int j = 0; j < H; j++) if (img[i][j] != exp_img[i][j]) n++;
        return n;
    endfunction

    task automatic model_fill(input int x0, input int y0, input int w, input int h, input int col);
        for (int j = y0; j < y0 + h; j++)
            for (int i = x0; i < x0 + w; i++) begin
                exp_img[i][j] = col;
                exp_plots++;
            end
    endtask

    task automatic model_cmd(input int c);
        int cyc;
        clr_exp();
        exp_plots = 0;
        exp_first_k = 1;
        case (c)
            0: begin model_fill(0, 0, W, H, 0); exp_lat = W * H + 1; end
            1: begin
                for (int dy = 0; dy <= 4 * T; dy++)
                    for (int dx = 0; dx <= 4 * T; dx++)
                        if (dx % T == 0 || dy % T == 0) begin
                            exp_img[X0 + dx][Y0 + dy] = 7;
                            exp_plots++;
                        end
                exp_lat = (4 * T + 1) * (4 * T + 1) + 1;
            end
            2, 3, 4: begin
                model_fill(X0, Y0 + 4 * T + 4, 4 * T, 8, (c == 2) ? 2 : (c == 3) ? 6 : 4);
                exp_lat = 4 * T * 8 + 1;
            end
            5: begin
                cyc = 0;
                exp_first_k = -1;
                for (int idx = 0; idx < 16; idx++) begin
                    int v;
                    v = int'(board[idx]);
                    if (Skip && v == 0) cyc += 2;
                    else begin
                        if (exp_first_k < 0) exp_first_k = cyc + 3;
                        model_fill(X0 + 1 + T * (idx % 4), Y0 + 1 + T * (idx / 4), T - 1, T - 1,
                                   (v == 0) ? 0 : (v % 7) + 1);
                        cyc += 2 + (T - 1) * (T - 1);
                    end
                end
                exp_lat = cyc + 1;
            end
            default: begin exp_lat = 1; exp_first_k = -1; end
        endcase
    endtask

    // Issue one command and watch it to completion; abort_k > 0 pulls resetn at that cycle.
    task automatic run_cmd(input logic [2:0] c, input int budget, input int pulse_k,
                           input int abort_k);
        int k, wait_n, px, py;
        for (int i = 0; i < W; i++) for (int j = 0; j < H; j++) img[i][j] = -1;
        res_lat = -1; res_plots = 0; res_first_k = -1; res_bad = 0;
        res_fx = -1; res_fy = -1; res_lx = -1; res_ly = -1;
        res_busy_ok = 1'b1; res_ready_after = 1'b0;
        @(negedge clk);
        wait_n = 0;
        while (!bus.cmd_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
        if (!bus.cmd_ready) return;
        bus.cmd_valid = 1'b1;
        bus.cmd = c;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (k <= budget) begin
            if (abort_k > 0 && k == abort_k) begin
                res_abort_pre = bus.plot;
                resetn = 1'b0;
                #1;
                res_abort_plot = bus.plot;
                res_abort_busy = bus.busy;
                res_abort_seen = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.done || bus.plot) res_abort_seen = 1'b1;
                end
                resetn = 1'b1;
                return;
            end
            if (pulse_k > 0 && k == pulse_k) begin bus.cmd_valid = 1'b1; bus.cmd = CMD_CLEAR; end
            if (pulse_k > 0 && k == pulse_k + 2) bus.cmd_valid = 1'b0;
            if (bus.plot) begin
                px = int'(bus.x);
                py = int'(bus.y);
                if (px >= W || py >= H) res_bad++;
                else begin
                    if (img[px][py] != -1) res_bad++;
                    img[px][py] = int'(bus.colour);
                end
                if (res_first_k < 0) begin res_first_k = k; res_fx = px; res_fy = py; end
                res_lx = px;
                res_ly = py;
                res_plots++;
            end
            if (bus.done) begin
                if (bus.busy || bus.cmd_ready) res_busy_ok = 1'b0;
                res_lat = k;
                break;
            end else if (!bus.busy || bus.cmd_ready) res_busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        bus.cmd_valid = 1'b0;
        if (res_lat >= 0) begin
            @(negedge clk);
            res_ready_after = bus.cmd_ready;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 8;
        if (bus.cmd_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", bus.cmd_ready); end
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.plot !== 1'b0) begin n_errors++; $display("FAIL reset_plot: got %b want 0", bus.plot); end
        if (bus.x !== 8'd0) begin n_errors++; $display("FAIL reset_x: got %0d want 0", bus.x); end
        if (bus.y !== 7'd0) begin n_errors++; $display("FAIL reset_y: got %0d want 0", bus.y); end
        if (bus.colour !== 3'd0) begin n_errors++; $display("FAIL reset_colour: got %0d want 0", bus.colour); end
        if (bus.tile_addr !== 4'd0) begin n_errors++; $display("FAIL reset_addr: got %0d want 0", bus.tile_addr); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_rise: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_clear();
        model_cmd(0);
        run_cmd(CMD_CLEAR, 19300, 0, 0);
        n_checks += 8;
        if (res_lat != exp_lat) begin n_errors++; $display("FAIL clear_latency: got %0d want %0d", res_lat, exp_lat); end
        if (res_plots != exp_plots) begin n_errors++; $display("FAIL clear_plots: got %0d want %0d", res_plots, exp_plots); end
        if (res_first_k != exp_first_k) begin n_errors++; $display("FAIL clear_first_cycle: got %0d want %0d", res_first_k, exp_first_k); end
        if (res_fx != 0 || res_fy != 0) begin n_errors++; $display("FAIL clear_first_px: got (%0d,%0d) want (0,0)", res_fx, res_fy); end
        if (res_lx != W - 1 || res_ly != H - 1) begin n_errors++; $display("FAIL clear_last_px: got (%0d,%0d) want (159,119)", res_lx, res_ly); end
        if (img_diffs() != 0 || res_bad != 0) begin n_errors++; $display("FAIL clear_image: got %0d diffs %0d bad want 0", img_diffs(), res_bad); end
        if (!res_busy_ok) begin n_errors++; $display("FAIL clear_busy: got bad busy/ready while running want clean"); end
        if (!res_ready_after) begin n_errors++; $display("FAIL clear_ready_after: got 0 want 1"); end
    endtask

    task automatic test_grid(input string tag);
        model_cmd(1);
        run_cmd(CMD_GRID, 7000, 0, 0);
        n_checks += 6;
        if (res_lat != exp_lat) begin n_errors++; $display("FAIL %s_latency: got %0d want %0d", tag, res_lat, exp_lat); end
        if (res_plots != exp_plots) begin n_errors++; $display("FAIL %s_plots: got %0d want %0d", tag, res_plots, exp_plots); end
        if (img_diffs() != 0 || res_bad != 0) begin n_errors++; $display("FAIL %s_image: got %0d diffs %0d bad want 0", tag, img_diffs(), res_bad); end
        if (img[40][20] != 7 || img[120][100] != 7) begin n_errors++; $display("FAIL %s_corners: got %0d,%0d want 7,7", tag, img[40][20], img[120][100]); end
        if (img[41][21] != -1) begin n_errors++; $display("FAIL %s_interior: got %0d want unplotted", tag, img[41][21]); end
        if (!res_busy_ok || !res_ready_after) begin n_errors++; $display("FAIL %s_handshake: got busy_ok=%b ready=%b want 1,1", tag, res_busy_ok, res_ready_after); end
    endtask

    task automatic test_banner();
        for (int it = 0; it < 3; it++) begin
            int c, pk;
            c = (it == 0) ? 4 : int'($urandom_range(2, 4));
            pk = int'($urandom_range(3, 600));
            model_cmd(c);
            run_cmd(3'(c), 700, pk, 0);
            n_checks += 4;
            if (res_lat != exp_lat) begin n_errors++; $display("FAIL banner%0d_latency: got %0d want %0d", c, res_lat, exp_lat); end
            if (res_plots != exp_plots) begin n_errors++; $display("FAIL banner%0d_plots: got %0d want %0d", c, res_plots, exp_plots); end
            if (img_diffs() != 0 || res_bad != 0) begin n_errors++; $display("FAIL banner%0d_image: got %0d diffs %0d bad want 0", c, img_diffs(), res_bad); end
            if (!res_busy_ok || !res_ready_after) begin n_errors++; $display("FAIL banner%0d_handshake: got busy_ok=%b ready=%b want 1,1", c, res_busy_ok, res_ready_after); end
        end
    endtask

    task automatic test_unknown();
        for (int it = 0; it < 2; it++) begin
            int c;
            c = (it == 0) ? 7 : int'($urandom_range(6, 7));
            model_cmd(c);
            run_cmd(3'(c), 20, 0, 0);
            n_checks += 3;
            if (res_lat != exp_lat) begin n_errors++; $display("FAIL unknown%0d_latency: got %0d want %0d", c, res_lat, exp_lat); end
            if (res_plots != 0) begin n_errors++; $display("FAIL unknown%0d_plots: got %0d want 0", c, res_plots); end
            if (!res_busy_ok || !res_ready_after) begin n_errors++; $display("FAIL unknown%0d_handshake: got busy_ok=%b ready=%b want 1,1", c, res_busy_ok, res_ready_after); end
        end
    endtask

    // cmd_valid held high: each command costs acceptance, done and one idle cycle.
    task automatic test_back_to_back();
        int last_done = -1;
        int n_done = 0;
        int bad = 0;
        @(negedge clk);
        bus.cmd = 3'd6;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last_done >= 0 && k - last_done != 3) bad++;
                if (bus.cmd_ready) bad++;
                last_done = k;
                n_done++;
            end
        end
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (bad != 0) begin n_errors++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", bad); end
        if (n_done < 6) begin n_errors++; $display("FAIL b2b_count: got %0d dones want >=6", n_done); end
    endtask

    task automatic test_num_index();
        int want0;
        for (int i = 0; i < 16; i++) board[i] = 4'(i);
        model_cmd(5);
        run_cmd(CMD_NUM, 6000, 0, 0);
        want0 = Skip ? -1 : 0;
        n_checks += 8;
        if (res_lat != exp_lat) begin n_errors++; $display("FAIL num_latency: got %0d want %0d", res_lat, exp_lat); end
        if (res_first_k != exp_first_k) begin n_errors++; $display("FAIL num_first_cycle: got %0d want %0d", res_first_k, exp_first_k); end
        if (res_plots != exp_plots) begin n_errors++; $display("FAIL num_plots: got %0d want %0d", res_plots, exp_plots); end
        if (img_diffs() != 0 || res_bad != 0) begin n_errors++; $display("FAIL num_image: got %0d diffs %0d bad want 0", img_diffs(), res_bad); end
        if (img[61][21] != 2 || img[79][39] != 2) begin n_errors++; $display("FAIL num_tile1: got %0d,%0d want 2,2", img[61][21], img[79][39]); end
        if (img[101][41] != 1) begin n_errors++; $display("FAIL num_tile7: got %0d want 1", img[101][41]); end
        if (img[41][21] != want0) begin n_errors++; $display("FAIL num_tile0: got %0d want %0d", img[41][21], want0); end
        if (!res_busy_ok || !res_ready_after) begin n_errors++; $display("FAIL num_handshake: got busy_ok=%b ready=%b want 1,1", res_busy_ok, res_ready_after); end
    endtask

    task automatic test_num_random();
        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < 16; i++) board[i] = 4'($urandom_range(0, 15));
            board[$urandom_range(0, 15)] = 4'd0;
            board[$urandom_range(0, 15)] = 4'd0;
            model_cmd(5);
            run_cmd(CMD_NUM, 6000, 0, 0);
            n_checks += 3;
            if (res_lat != exp_lat) begin n_errors++; $display("FAIL numrnd%0d_latency: got %0d want %0d", it, res_lat, exp_lat); end
            if (res_first_k != exp_first_k) begin n_errors++; $display("FAIL numrnd%0d_first_cycle: got %0d want %0d", it, res_first_k, exp_first_k); end
            if (img_diffs() != 0 || res_bad != 0) begin n_errors++; $display("FAIL numrnd%0d_image: got %0d diffs %0d bad want 0", it, img_diffs(), res_bad); end
        end
    endtask

    task automatic test_abort();
        res_abort_pre = 1'b0; res_abort_plot = 1'b1; res_abort_busy = 1'b1; res_abort_seen = 1'b1;
        run_cmd(CMD_CLEAR, 19300, 0, 500);
        n_checks += 4;
        if (res_abort_pre !== 1'b1) begin n_errors++; $display("FAIL abort_pre_plot: got %b want 1", res_abort_pre); end
        if (res_abort_plot !== 1'b0) begin n_errors++; $display("FAIL abort_plot: got %b want 0", res_abort_plot); end
        if (res_abort_busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", res_abort_busy); end
        if (res_abort_seen !== 1'b0) begin n_errors++; $display("FAIL abort_quiet: got done/plot during reset want none"); end
        test_grid("abort_grid");
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd = '0;
        for (int i = 0; i < 16; i++) board[i] = 4'(i);
        test_reset();
        test_clear();
        test_grid("grid");
        test_banner();
        test_unknown();
        test_back_to_back();
        test_num_index();
        test_num_random();
        test_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
